pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 119 +++++++++++
 tb/tb_pc_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit with prioritised redirect, exception/misalign capture and an optional
// return-address stack compiled in by defining PC_UNIT_RAS_EN.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             pcsrc,
  input  logic             jump,
  input  logic             link,
  input  logic             jr,
  input  logic             ret,
  input  logic             exc,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] jpc,
  input  logic [WIDTH-1:0] jrpc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] epc,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] epc_d;
  logic [WIDTH-1:0] jr_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             mis_d;
  logic             do_push;
  logic             do_pop;
  logic             ras_nonempty;

  assign pc4 = pc + WIDTH'(4);

  // Next-PC selection: exc, stall, jr, jump, pcsrc, sequential; reset handled in the register.
  always_comb begin
    pc_d    = pc;
    epc_d   = epc;
    mis_d   = misalign;
    jr_tgt  = jrpc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (exc) begin
      pc_d  = EXC_VEC;
      epc_d = pc;
      mis_d = 1'b0;
    end else if (!stall) begin
      mis_d = 1'b0;
      if (jr) begin
        if (ret && ras_nonempty) begin
          jr_tgt = ras_top;
          do_pop = 1'b1;
        end
        if (jr_tgt[1:0] != 2'b00) begin
          pc_d  = EXC_VEC;
          epc_d = pc;
          mis_d = 1'b1;
        end else begin
          pc_d = jr_tgt;
        end
      end else if (jump) begin
        pc_d    = jpc;
        do_push = link;
      end else if (pcsrc) begin
        pc_d = npc;
      end else begin
        pc_d = pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_d;
      epc      <= epc_d;
      misalign <= mis_d;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [CW-1:0]    ras_cnt;

  // Circular buffer: ras_ptr is the next write slot, so a full push silently drops the oldest.
  assign ras_top      = ras_mem[ras_ptr - PW'(1)];
  assign ras_nonempty = (ras_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_mem[ras_ptr] <= pc4;
      ras_ptr          <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (do_pop) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end
`else
  logic unused_ok;
  assign ras_top      = '0;
  assign ras_nonempty = 1'b0;
  assign unused_ok    = do_push | do_pop | (RAS_DEPTH == 0);
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset, stall, pcsrc, jump, link, jr, ret, exc;
  logic [31:0] npc, jpc, jrpc;
  logic [31:0] pc, pc4, epc;
  logic        misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_stack[$];
  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          ras_on;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc), .jump(jump), .link(link),
    .jr(jr), .ret(ret), .exc(exc), .npc(npc), .jpc(jpc), .jrpc(jrpc),
    .pc(pc), .pc4(pc4), .epc(epc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge state.
  task automatic step(input logic r, input logic s, input logic ps, input logic j,
                      input logic l, input logic jrr, input logic rt, input logic e,
                      input logic [31:0] n, input logic [31:0] jp, input logic [31:0] jrp);
    logic [31:0] tgt;
    reset = r; stall = s; pcsrc = ps; jump = j; link = l; jr = jrr; ret = rt; exc = e;
    npc = n; jpc = jp; jrpc = jrp;
    if (r) begin
      m_pc = RST_PC; m_epc = 0; m_mis = 0; m_stack.delete();
    end else if (e) begin
      m_epc = m_pc; m_pc = EXC_PC; m_mis = 0;
    end else if (!s) begin
      m_mis = 0;
      if (jrr) begin
        if (ras_on && rt && m_stack.size() > 0) tgt = m_stack.pop_back();
        else tgt = jrp;
        if (tgt % 4 != 0) begin
          m_epc = m_pc; m_pc = EXC_PC; m_mis = 1;
        end else m_pc = tgt;
      end else if (j) begin
        if (ras_on && l) begin
          m_stack.push_back(m_pc + 32'd4);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
        end
        m_pc = jp;
      end else if (ps) m_pc = n;
      else m_pc = m_pc + 32'd4;
    end
    sb.push_back('{pc: m_pc, epc: m_epc, mis: m_mis});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic go(input logic [31:0] a);
    step(0, 0, 0, 1, 0, 0, 0, 0, 32'h0, a, 32'h0);
  endtask

  // Monitor: one expected entry is due after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_cmp++;
        if (pc !== x.pc) begin
          n_bad++; $display("FAIL pc: got %h want %h at %0t", pc, x.pc, $time);
        end
        n_cmp++;
        if (epc !== x.epc) begin
          n_bad++; $display("FAIL epc: got %h want %h at %0t", epc, x.epc, $time);
        end
        n_cmp++;
        if (misalign !== x.mis) begin
          n_bad++; $display("FAIL misalign: got %b want %b at %0t", misalign, x.mis, $time);
        end
        n_cmp++;
        if (pc4 !== x.pc + 32'd4) begin
          n_bad++; $display("FAIL pc4: got %h want %h at %0t", pc4, x.pc + 32'd4, $time);
        end
      end
    end
  end

  initial begin
`ifdef PC_UNIT_RAS_EN
    ras_on = 1'b1;
`else
    ras_on = 1'b0;
`endif
    {reset, stall, pcsrc, jump, link, jr, ret, exc} = '0;
    npc = 0; jpc = 0; jrpc = 0;
    m_pc = 0; m_epc = 0; m_mis = 0;
    @(negedge clk);

    // Reset then free-run: 3000, 3004, 3008
    do_reset();
    idle(); idle();

    // All three redirects together: jr wins
    step(0, 0, 1, 1, 0, 1, 0, 0, 32'h0000_3200, 32'h0000_3300, 32'h0000_3100);

    // stall+exc at 0x3010
    do_reset();
    repeat (4) idle();
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);

    // Misaligned jr at 0x3020 followed by a 3-cycle stall
    do_reset();
    go(32'h0000_3020);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0000_3102);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    idle();

    // Unchecked alignment on jump/pcsrc, and pc4 wrap
    go(32'h0000_5001);
    step(0, 0, 1, 0, 0, 0, 0, 0, 32'h0000_6002, 32'h0, 32'h0);
    go(32'hFFFF_FFFC);
    idle(); idle();

    // Five calls, five returns through a 4-deep stack
    do_reset();
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0000_3000 + 32'(i) * 32'h10, 32'h0);
    repeat (5) step(0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0000_3F00);

    // Reset during a stall at 0x3050, with a call pending on the stack
    step(0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0000_3050, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0000_3F00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b, c;
      a = {$urandom_range(32'h3FFF, 32'h3000), 2'b00} & 32'h0000_FFFC;
      b = {$urandom_range(32'h3FFF, 32'h3000), 2'b00} & 32'h0000_FFFC;
      c = {$urandom_range(32'h3FFF, 32'h3000), 2'b00} & 32'h0000_FFFC;
      if ($urandom_range(7) == 0) c[1:0] = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) a[0] = 1'b1;
      step(($urandom_range(60) == 0), ($urandom_range(5) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(1) == 0), ($urandom_range(4) == 0),
           ($urandom_range(1) == 0), ($urandom_range(25) == 0), a, b, c);
    end
    idle();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
